// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - state encoding, opcodes and control-select constants for the multicycle controller
package mips_mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_RD    = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WR    = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EXEC = 4'd10,
      S_ADDI_WB   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
   } ctrl_t;

endpackage

// File: rtl/mips_multicycle_controller_if.sv
// rtl/mips_multicycle_controller_if.sv - controller <-> datapath/memory control bundle
interface mips_multicycle_controller_if #(
   parameter int CNT_W = 32
) ();
   logic [5:0]       opcode;
   logic [5:0]       func;
   logic             zero;
   logic             mem_ready;
   logic             pc_write;
   logic             pc_write_cond;
   logic [1:0]       pc_source;
   logic             i_or_d;
   logic             mem_read;
   logic             mem_write;
   logic             ir_write;
   logic             reg_dst;
   logic             mem_to_reg;
   logic             reg_write;
   logic             alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       alu_op;
   logic [3:0]       state_o;
   logic [CNT_W-1:0] instr_retired;
   logic             illegal_op;
   logic             mem_timeout;

   modport master (
      input  opcode, func, zero, mem_ready,
      output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
             ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
             alu_op, state_o, instr_retired, illegal_op, mem_timeout
   );

   modport slave (
      output opcode, func, zero, mem_ready,
      input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
             ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
             alu_op, state_o, instr_retired, illegal_op, mem_timeout
   );
endinterface

// File: rtl/mips_multicycle_controller_output_decode.sv
// rtl/mips_multicycle_controller_output_decode.sv - mc_output_decode: pure state -> control-vector map
module mc_output_decode
   import mips_mc_pkg::*;
(
   input  state_t state,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.pc_source = PCSRC_ALU;
            ctrl.ir_write  = 1'b1;
            ctrl.pc_write  = 1'b1;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SH;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEM_ADDR, S_ADDI_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEM_RD: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         S_R_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALUOP_FUNC;
         end
         S_R_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_REG;
            ctrl.alu_op        = ALUOP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
         end
         S_ADDI_WB: begin
            ctrl.reg_write = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_controller.sv
// rtl/mips_multicycle_controller.sv - multicycle MIPS control FSM; MC_TIMEOUT_EN enables the memory-wait watchdog
module mips_multicycle_controller
   import mips_mc_pkg::*;
#(
   parameter int CNT_W          = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic                         clk,
   input logic                         rst,
   mips_multicycle_controller_if.master bus
);

   state_t           state;
   state_t           next_state;
   ctrl_t            dec_ctrl;
   ctrl_t            ctrl;
   logic             illegal;
   logic             timeout;
   logic             retire;
   logic [CNT_W-1:0] retired_cnt;

   // func and zero are consumed by the ALU-control stage and PC logic, not here
   logic unused_inputs;
   assign unused_inputs = ^{bus.func, bus.zero};

   mc_output_decode u_decode (
      .state (state),
      .ctrl  (dec_ctrl)
   );

   always_ff @(posedge clk) begin
      if (!rst) state <= S_FETCH;
      else      state <= next_state;
   end

   always_comb begin
      next_state = S_FETCH;
      illegal    = 1'b0;
      case (state)
         S_FETCH:  next_state = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.opcode)
               OP_RTYPE:     next_state = S_R_EXEC;
               OP_LW, OP_SW: next_state = S_MEM_ADDR;
               OP_BEQ:       next_state = S_BRANCH;
               OP_J:         next_state = S_JUMP;
               OP_ADDI:      next_state = S_ADDI_EXEC;
               default: begin
                  next_state = S_FETCH;
                  illegal    = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR:  next_state = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:    next_state = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
         S_MEM_WR:    next_state = bus.mem_ready ? S_FETCH : S_MEM_WR;
         S_R_EXEC:    next_state = S_R_WB;
         S_ADDI_EXEC: next_state = S_ADDI_WB;
         default:     next_state = S_FETCH;
      endcase
      if (timeout) next_state = S_FETCH;
   end

`ifdef MC_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WAIT_W-1:0] wait_cnt;
   logic              wait_state;

   assign wait_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
   assign timeout    = rst && wait_state && !bus.mem_ready &&
                       (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

   // staying in a wait state implies mem_ready=0; any state change or abort restarts the count
   always_ff @(posedge clk) begin
      if (!rst || timeout || (next_state != state)) wait_cnt <= '0;
      else if (wait_state)                          wait_cnt <= wait_cnt + WAIT_W'(1);
   end
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif

   assign retire = rst && !timeout &&
                   ((state inside {S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB}) ||
                    ((state == S_MEM_WR) && bus.mem_ready));

   always_ff @(posedge clk) begin
      if (!rst)        retired_cnt <= '0;
      else if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
   end

   // fetch commits only on the mem_ready cycle; reset silences every output
   always_comb begin
      ctrl = dec_ctrl;
      if ((state == S_FETCH) && !bus.mem_ready) begin
         ctrl.ir_write = 1'b0;
         ctrl.pc_write = 1'b0;
      end
      if (!rst) ctrl = '0;
   end

   assign bus.pc_write      = ctrl.pc_write;
   assign bus.pc_write_cond = ctrl.pc_write_cond;
   assign bus.pc_source     = ctrl.pc_source;
   assign bus.i_or_d        = ctrl.i_or_d;
   assign bus.mem_read      = ctrl.mem_read;
   assign bus.mem_write     = ctrl.mem_write;
   assign bus.ir_write      = ctrl.ir_write;
   assign bus.reg_dst       = ctrl.reg_dst;
   assign bus.mem_to_reg    = ctrl.mem_to_reg;
   assign bus.reg_write     = ctrl.reg_write;
   assign bus.alu_src_a     = ctrl.alu_src_a;
   assign bus.alu_src_b     = ctrl.alu_src_b;
   assign bus.alu_op        = ctrl.alu_op;
   assign bus.state_o       = state;
   assign bus.instr_retired = retired_cnt;
   assign bus.illegal_op    = rst && illegal;
   assign bus.mem_timeout   = timeout;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb/tb_mips_multicycle_controller.sv - directed scoreboard bench for mips_multicycle_controller
module tb_mips_multicycle_controller;

   localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_MA = 4'd2, S_MR = 4'd3, S_MWB = 4'd4,
                          S_MW = 4'd5, S_RE = 4'd6, S_RWB = 4'd7, S_BR = 4'd8, S_J = 4'd9,
                          S_AE = 4'd10, S_AWB = 4'd11;
   localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011,
                          O_BEQ = 6'b000100, O_J = 6'b000010, O_ADDI = 6'b001000,
                          O_BAD = 6'b111111;

   typedef struct {
      logic [3:0]  st;
      logic        rdy;
      logic [5:0]  op;
      logic        ill;
      logic [31:0] ret;
   } step_t;

   logic        clk = 1'b0;
   logic        rst;
   int          checks = 0;
   int          errors = 0;
   int unsigned ret_model = 0;
   step_t       sb[$];
   logic [15:0] ctrl_obs;

   always #5 clk = ~clk;

   mips_multicycle_controller_if #(.CNT_W(32)) bus ();

   mips_multicycle_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   assign ctrl_obs = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d, bus.mem_read,
                      bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                      bus.alu_src_a, bus.alu_src_b, bus.alu_op};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic rdy);
      logic       pcw, pcwc, iord, mr, mw, irw, rd, m2r, rw, a;
      logic [1:0] pcs, b, aop;
      {pcw, pcwc, iord, mr, mw, irw, rd, m2r, rw, a} = '0;
      {pcs, b, aop} = '0;
      case (st)
         S_F:   begin mr = 1; b = 2'b01; irw = rdy; pcw = rdy; end
         S_D:   b = 2'b11;
         S_MA:  begin a = 1; b = 2'b10; end
         S_MR:  begin mr = 1; iord = 1; end
         S_MWB: begin rw = 1; m2r = 1; end
         S_MW:  begin mw = 1; iord = 1; end
         S_RE:  begin a = 1; aop = 2'b10; end
         S_RWB: begin rw = 1; rd = 1; end
         S_BR:  begin a = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
         S_J:   begin pcw = 1; pcs = 2'b10; end
         S_AE:  begin a = 1; b = 2'b10; end
         S_AWB: rw = 1;
         default: ;
      endcase
      return {pcw, pcwc, pcs, iord, mr, mw, irw, rd, m2r, rw, a, b, aop};
   endfunction

   task automatic push(input logic [3:0] st, input logic rdy, input logic [5:0] op);
      step_t s;
      s.st  = st;
      s.rdy = rdy;
      s.op  = op;
      s.ill = (st == S_D) && !(op inside {O_R, O_LW, O_SW, O_BEQ, O_J, O_ADDI});
      s.ret = ret_model;
      if ((st inside {S_MWB, S_RWB, S_BR, S_J, S_AWB}) || ((st == S_MW) && rdy)) ret_model++;
      sb.push_back(s);
   endtask

   task automatic drain();
      step_t s;
      while (sb.size() > 0) begin
         s = sb.pop_front();
         bus.opcode    = s.op;
         bus.mem_ready = s.rdy;
         @(negedge clk);
         chk("state", 32'(bus.state_o), 32'(s.st));
         chk($sformatf("ctrl@%0d", s.st), 32'(ctrl_obs), 32'(exp_ctrl(s.st, s.rdy)));
         chk($sformatf("illegal_op@%0d", s.st), 32'(bus.illegal_op), 32'(s.ill));
         chk("instr_retired", bus.instr_retired, s.ret);
         chk("mem_timeout", 32'(bus.mem_timeout), 32'(0));
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b0;
      bus.opcode = O_R;
      bus.func = 6'h20;
      bus.zero = 1'b1;
      bus.mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ctrl", 32'(ctrl_obs), 32'(0));
      chk("reset_state", 32'(bus.state_o), 32'(S_F));
      chk("reset_retired", bus.instr_retired, 32'(0));
      chk("reset_illegal", 32'(bus.illegal_op), 32'(0));
      @(posedge clk);
      #1;
      rst = 1'b1;

      // R-type, then lw with three stalled reads
      push(S_F, 1, O_R); push(S_D, 1, O_R); push(S_RE, 1, O_R); push(S_RWB, 1, O_R);
      push(S_F, 1, O_LW); push(S_D, 1, O_LW); push(S_MA, 0, O_LW);
      for (int i = 0; i < 3; i++) push(S_MR, 0, O_LW);
      push(S_MR, 1, O_LW); push(S_MWB, 0, O_LW);
      // sw with a stalled fetch and a stalled write
      push(S_F, 0, O_SW); push(S_F, 1, O_SW); push(S_D, 0, O_SW); push(S_MA, 1, O_SW);
      push(S_MW, 0, O_SW); push(S_MW, 1, O_SW);
      push(S_F, 1, O_BEQ); push(S_D, 1, O_BEQ); push(S_BR, 0, O_BEQ);
      push(S_F, 1, O_J); push(S_D, 1, O_J); push(S_J, 1, O_J);
      push(S_F, 1, O_BAD); push(S_D, 1, O_BAD);
      push(S_F, 1, O_ADDI); push(S_D, 1, O_ADDI); push(S_AE, 1, O_ADDI); push(S_AWB, 1, O_ADDI);
      drain();

`ifdef MC_TIMEOUT_EN
      begin
         int hit = 0;
         logic saw_pcw = 1'b0;
         bus.mem_ready = 1'b0;
         for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.pc_write || bus.ir_write) saw_pcw = 1'b1;
            if (bus.mem_timeout) begin
               hit = i;
               @(posedge clk);
               #1;
               break;
            end
            @(posedge clk);
            #1;
         end
         chk("timeout_cycle", 32'(hit), 32'(16));
         chk("timeout_no_pc_write", 32'(saw_pcw), 32'(0));
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("timeout_single_pulse", 32'(bus.mem_timeout), 32'(0));
            chk("timeout_state", 32'(bus.state_o), 32'(S_F));
            @(posedge clk);
            #1;
         end
         chk("timeout_retired", bus.instr_retired, ret_model);
      end
`endif

      // reset in the middle of a store
      push(S_F, 1, O_SW); push(S_D, 1, O_SW); push(S_MA, 1, O_SW); push(S_MW, 0, O_SW);
      drain();
      rst = 1'b0;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      chk("rst_midwr_mem_write", 32'(bus.mem_write), 32'(0));
      chk("rst_midwr_ctrl", 32'(ctrl_obs), 32'(0));
      @(posedge clk);
      #1;
      chk("rst_midwr_state", 32'(bus.state_o), 32'(S_F));
      chk("rst_midwr_retired", bus.instr_retired, 32'(0));
      ret_model = 0;
      rst = 1'b1;

      push(S_F, 1, O_R); push(S_D, 1, O_R); push(S_RE, 1, O_R); push(S_RWB, 1, O_R);
      push(S_F, 0, O_R);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
